mem_bank_ctr: RTL and testbench
===============================

Name: mem_bank_ctr

Overview:
- Parametrised bank controller that maps one read port and one write port of a FIFO onto 2^BANK_W single-port RAM banks.
- Banks are interleaved on the low address bits.
- A read/write collision on the same bank is resolved with a per-bank one-entry deferred-write slot; the slot drains on the next cycle that bank is free.
- Sits between the FIFO pointer logic and the SPRAM instances; also returns registered read data.

Parameters:
ADDR_W, 3, full FIFO word address width.
DATA_W, 8, data word width.
BANK_W, 1, log2 of bank count NB; NB = 2^BANK_W; 1 <= BANK_W < ADDR_W.
BA_W, ADDR_W-BANK_W (derived localparam), per-bank address width.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
r_req  in  1  read request; always accepted.
r_addr  in  ADDR_W  read address; bank = r_addr[BANK_W-1:0], row = r_addr[ADDR_W-1:BANK_W].
r_valid  out  1  read data valid, one cycle after r_req.
r_data  out  DATA_W  read data.
w_req  in  1  write request.
w_ready  out  1  write accepted when w_req && w_ready.
w_addr  in  ADDR_W  write address, same split as r_addr.
w_data  in  DATA_W  write data.
bank_en  out  NB  per-bank enable.
bank_we  out  NB  per-bank write enable.
bank_addr  out  NB*BA_W  per-bank row address; bank i at [i*BA_W +: BA_W].
bank_wdata  out  NB*DATA_W  per-bank write data.
bank_rdata  in  NB*DATA_W  per-bank read data; SPRAM has 1-cycle read latency.
pend_cnt  out  BANK_W+1  number of occupied deferred slots.

Behaviour:
- Reset is synchronous, active-high; clock is clk.
- While rst is high or in the cycle after it:
  - all slots invalid;
  - r_valid = 0, r_data = 0, pend_cnt = 0;
  - bank_en/bank_we = 0;
  - w_ready = 0 while rst is high.
- Reset mid-operation discards pending slot contents; no RAM write is issued for them.
- Per-bank arbitration, each cycle, for bank b:
  - Priority: read to b > slot[b] drain > new write to b.
  - Read hit on b: bank_en[b] = 1, bank_we[b] = 0, addr = read row.
  - Otherwise, slot[b] valid: write slot row/data; slot cleared unless refilled this cycle.
  - Otherwise, accepted write to b: direct write.
- Write acceptance (combinational, bank wb = write bank, rd_b = read targets wb):
  - slot[wb] empty, !rd_b: write direct to RAM, w_ready = 1.
  - slot[wb] empty, rd_b: write captured into slot[wb], w_ready = 1.
  - slot[wb] full, !rd_b: slot drains to RAM, new write captured into slot[wb], w_ready = 1.
  - slot[wb] full, rd_b: w_ready = 0; write not accepted; slot holds.
- Per-bank write order is always preserved; at most one RAM op per bank per cycle.
- Idle banks: bank_en = 0, bank_we = 0; bank_addr/bank_wdata drive the slot contents (don't-care otherwise, but stable).
- Read return:
  - Register r_req and the read bank index.
  - Next cycle: r_valid = 1 and r_data = bank_rdata of the registered bank.
  - When r_valid = 0, r_data holds its last value.
- pend_cnt = popcount of slot valid bits, registered.
- Simultaneous read and write to the same bank and row: the read returns the old RAM content unless FWD is enabled.

Optional Feature:
- Macro MEM_BANK_CTR_FWD_EN.
- Defined:
  - On r_req, compare r_addr against the valid slot of its bank and against a write being captured into that slot this cycle.
  - On a match, latch the youngest matching data; next cycle r_data returns it instead of bank_rdata.
  - Latency stays 1.
- Undefined: no compare logic; r_data always comes from bank_rdata, so stale data is possible on a pending-address hit.

Test Plan:
- Reset, BANK_W=1: hold rst 2 cycles -> r_valid=0, bank_en=2'b00, pend_cnt=0, w_ready=0 during rst; w_ready=1 after.
- Write addr 3 (0xA5) with no read -> bank_we=2'b10, bank_addr[1]=1 same cycle; read addr 3 later -> r_valid next cycle, r_data=0xA5.
- Read addr 2 plus write addr 4 (0x3C), both bank 0, same cycle -> bank 0 read, pend_cnt=1; next idle cycle bank_we[0]=1, row 2, data 0x3C; pend_cnt=0.
- Slot[0] full, then read addr 0 plus write addr 6 -> w_ready=0, slot unchanged; next cycle, no read -> slot drains, addr 6 captured, w_ready=1.
- BANK_W=2, ADDR_W=5: streaming writes 0..31 concurrent with reads lagging by 4 -> no data loss; reads return written values in order; pend_cnt <= 4.
- FWD_EN: write addr 4 (0x77) deferred, then read addr 4 before drain -> r_data=0x77; without the macro -> old RAM value.

Source files
------------

// File: rtl/mem_bank_ctr.sv
// Bank controller: maps one FIFO read port and one write port onto 2^BANK_W interleaved SPRAM banks.
// Optional read forwarding from the deferred-write slots: define MEM_BANK_CTR_FWD_EN.
module mem_bank_ctr #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BANK_W = 1,
  localparam int unsigned NB    = 1 << BANK_W,
  localparam int unsigned BA_W  = ADDR_W - BANK_W,
  localparam int unsigned CNT_W = BANK_W + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 r_req,
  input  logic [ADDR_W-1:0]    r_addr,
  output logic                 r_valid,
  output logic [DATA_W-1:0]    r_data,
  input  logic                 w_req,
  output logic                 w_ready,
  input  logic [ADDR_W-1:0]    w_addr,
  input  logic [DATA_W-1:0]    w_data,
  output logic [NB-1:0]        bank_en,
  output logic [NB-1:0]        bank_we,
  output logic [NB*BA_W-1:0]   bank_addr,
  output logic [NB*DATA_W-1:0] bank_wdata,
  input  logic [NB*DATA_W-1:0] bank_rdata,
  output logic [CNT_W-1:0]     pend_cnt
);

  logic [BANK_W-1:0] rb, wb;
  logic [BA_W-1:0]   r_row, w_row;
  assign rb    = r_addr[BANK_W-1:0];
  assign wb    = w_addr[BANK_W-1:0];
  assign r_row = r_addr[ADDR_W-1:BANK_W];
  assign w_row = w_addr[ADDR_W-1:BANK_W];

  logic [NB-1:0]     slot_vld, slot_vld_nxt;
  logic [BA_W-1:0]   slot_row  [NB];
  logic [DATA_W-1:0] slot_data [NB];
  logic [NB-1:0]     rd_hit, capture;
  logic              rd_wb, w_acc;

  // Per-bank arbitration: read > slot drain > direct write; collisions go to the slot.
  always_comb begin
    bank_en      = '0;
    bank_we      = '0;
    bank_addr    = '0;
    bank_wdata   = '0;
    rd_hit       = '0;
    capture      = '0;
    slot_vld_nxt = slot_vld;
    rd_wb        = r_req && (rb == wb);
    w_ready      = !rst && !(slot_vld[wb] && rd_wb);
    w_acc        = w_req && w_ready;
    for (int b = 0; b < NB; b++) begin
      rd_hit[b]  = !rst && r_req && (rb == BANK_W'(b));
      capture[b] = w_acc && (wb == BANK_W'(b)) && (rd_hit[b] || slot_vld[b]);
      bank_addr[b*BA_W +: BA_W]      = slot_row[b];
      bank_wdata[b*DATA_W +: DATA_W] = slot_data[b];
      if (rd_hit[b]) begin
        bank_en[b]                = 1'b1;
        bank_addr[b*BA_W +: BA_W] = r_row;
      end else if (slot_vld[b] && !rst) begin
        bank_en[b]      = 1'b1;
        bank_we[b]      = 1'b1;
        slot_vld_nxt[b] = 1'b0;
      end else if (w_acc && (wb == BANK_W'(b))) begin
        bank_en[b]                     = 1'b1;
        bank_we[b]                     = 1'b1;
        bank_addr[b*BA_W +: BA_W]      = w_row;
        bank_wdata[b*DATA_W +: DATA_W] = w_data;
      end
      if (capture[b]) slot_vld_nxt[b] = 1'b1;
      if (rst)        slot_vld_nxt[b] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) slot_vld <= '0;
    else     slot_vld <= slot_vld_nxt;
    for (int b = 0; b < NB; b++) begin
      if (capture[b]) begin
        slot_row[b]  <= w_row;
        slot_data[b] <= w_data;
      end
    end
  end

  // Occupancy count tracks the slot register contents.
  logic [CNT_W-1:0] cnt_nxt, pend_q;
  always_comb begin
    cnt_nxt = '0;
    for (int b = 0; b < NB; b++) cnt_nxt = cnt_nxt + CNT_W'(slot_vld_nxt[b]);
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= cnt_nxt;
  end
  assign pend_cnt = rst ? '0 : pend_q;

  logic              rv_q;
  logic [BANK_W-1:0] rbank_q;
  logic [DATA_W-1:0] rd_ram, rd_mux, r_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      rv_q    <= 1'b0;
      rbank_q <= '0;
    end else begin
      rv_q    <= r_req;
      rbank_q <= rb;
    end
  end

  always_comb begin
    rd_ram = '0;
    for (int b = 0; b < NB; b++)
      if (rbank_q == BANK_W'(b)) rd_ram = bank_rdata[b*DATA_W +: DATA_W];
  end

`ifdef MEM_BANK_CTR_FWD_EN
  // Youngest pending write to the read address wins: a same-cycle capture beats the slot.
  logic              fwd_hit_c, fwd_hit_q;
  logic [DATA_W-1:0] fwd_val_c, fwd_data_q;
  always_comb begin
    fwd_hit_c = 1'b0;
    fwd_val_c = '0;
    for (int b = 0; b < NB; b++) begin
      if (rb == BANK_W'(b)) begin
        if (slot_vld[b] && (slot_row[b] == r_row)) begin
          fwd_hit_c = 1'b1;
          fwd_val_c = slot_data[b];
        end
        if (capture[b] && (w_row == r_row)) begin
          fwd_hit_c = 1'b1;
          fwd_val_c = w_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_hit_q  <= r_req && fwd_hit_c;
      fwd_data_q <= fwd_val_c;
    end
  end
  assign rd_mux = fwd_hit_q ? fwd_data_q : rd_ram;
`else
  assign rd_mux = rd_ram;
`endif

  always_ff @(posedge clk) begin
    if (rst)       r_hold <= '0;
    else if (rv_q) r_hold <= rd_mux;
  end

  assign r_valid = rv_q && !rst;
  assign r_data  = rst ? '0 : (rv_q ? rd_mux : r_hold);

endmodule

// File: tb/tb_mem_bank_ctr.sv
// Bench for mem_bank_ctr: SPRAM bank models, reference memory model and read-data scoreboard.
module tb_mem_bank_ctr;
  localparam int AW  = 3;
  localparam int DW  = 8;
  localparam int BW  = 1;
  localparam int NB  = 1 << BW;
  localparam int BAW = AW - BW;
  localparam int NA  = 1 << AW;
  localparam int NR  = 1 << BAW;

  logic              clk = 1'b0;
  logic              rst;
  logic              r_req, w_req, w_ready, r_valid;
  logic [AW-1:0]     r_addr, w_addr;
  logic [DW-1:0]     r_data, w_data;
  logic [NB-1:0]     bank_en, bank_we;
  logic [NB*BAW-1:0] bank_addr;
  logic [NB*DW-1:0]  bank_wdata, bank_rdata;
  logic [BW:0]       pend_cnt;

  mem_bank_ctr #(.ADDR_W(AW), .DATA_W(DW), .BANK_W(BW)) dut (
    .clk(clk), .rst(rst),
    .r_req(r_req), .r_addr(r_addr), .r_valid(r_valid), .r_data(r_data),
    .w_req(w_req), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data),
    .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  // SPRAM banks with one-cycle read latency
  logic          ram_clr;
  logic [DW-1:0] sram  [NB][NR];
  logic [DW-1:0] rdq   [NB];
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (ram_clr) begin
        for (int r = 0; r < NR; r++) sram[b][r] <= '0;
      end else if (bank_en[b]) begin
        if (bank_we[b]) sram[b][bank_addr[b*BAW +: BAW]] <= bank_wdata[b*DW +: DW];
        else            rdq[b] <= sram[b][bank_addr[b*BAW +: BAW]];
      end
    end
  end
  always_comb for (int b = 0; b < NB; b++) bank_rdata[b*DW +: DW] = rdq[b];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: ram_m = what is in the RAM, lmem = latest accepted write per address,
  // pend* = the single outstanding deferred write per bank.
  logic [DW-1:0] ram_m [NA];
  logic [DW-1:0] lmem  [NA];
  bit            pv [NB];
  int            pa [NB];
  logic [DW-1:0] pd [NB];
  logic [DW-1:0] exp_q [$];

  logic          c_rq, c_wq, exp_ready;
  logic [AW-1:0] c_ra, c_wa;
  logic [DW-1:0] c_wd;

  function automatic int pend_model();
    int n = 0;
    for (int b = 0; b < NB; b++) n += int'(pv[b]);
    return n;
  endfunction

  task automatic drive(input logic rq, input logic [AW-1:0] ra, input logic wq,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    chk("pend_cnt", 32'(pend_cnt), 32'(pend_model()));
    c_rq = rq; c_ra = ra; c_wq = wq; c_wa = wa; c_wd = wd;
    r_req = rq; r_addr = ra; w_req = wq; w_addr = wa; w_data = wd;
    exp_ready = !(pv[int'(wa) % NB] && rq && (int'(ra) % NB == int'(wa) % NB));
    #1;
    chk("w_ready", 32'(w_ready), 32'(exp_ready));
  endtask

  task automatic step(output logic acc);
    int rb = int'(c_ra) % NB;
    int wb = int'(c_wa) % NB;
    bit was = pv[wb];
    logic [DW-1:0] er = ram_m[c_ra];
    for (int b = 0; b < NB; b++)
      if (pv[b] && !(c_rq && rb == b)) begin
        ram_m[pa[b]] = pd[b];
        pv[b] = 1'b0;
      end
    acc = c_wq && exp_ready;
    if (acc) begin
      lmem[c_wa] = c_wd;
      if ((c_rq && rb == wb) || was) begin
        pv[wb] = 1'b1; pa[wb] = int'(c_wa); pd[wb] = c_wd;
      end else begin
        ram_m[c_wa] = c_wd;
      end
    end
`ifdef MEM_BANK_CTR_FWD_EN
    er = lmem[c_ra];
`endif
    if (c_rq) exp_q.push_back(er);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    logic a;
    drive(1'b0, '0, 1'b0, '0, '0);
    step(a);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; r_req = 1'b1; w_req = 1'b1; r_addr = '0; w_addr = '0; w_data = 8'hFF;
    #1;
    chk("rst_w_ready", 32'(w_ready), 0);
    chk("rst_bank_en", 32'(bank_en), 0);
    chk("rst_bank_we", 32'(bank_we), 0);
    chk("rst_r_valid", 32'(r_valid), 0);
    chk("rst_pend_cnt", 32'(pend_cnt), 0);
    chk("rst_r_data", 32'(r_data), 0);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    for (int b = 0; b < NB; b++) pv[b] = 1'b0;
    for (int a = 0; a < NA; a++) lmem[a] = ram_m[a];
    exp_q.delete();
    rst = 1'b0; r_req = 1'b0; w_req = 1'b0;
    #1;
    chk("post_rst_w_ready", 32'(w_ready), 1);
    chk("post_rst_bank_en", 32'(bank_en), 0);
    @(posedge clk); #1;
    chk("post_rst_r_valid", 32'(r_valid), 0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (r_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_r_valid", 32'(r_valid), 0);
      else chk("r_data", 32'(r_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    logic acc;
    int tries;
    ram_clr = 1'b1;
    rst = 1'b1; r_req = 1'b1; w_req = 1'b1; r_addr = '0; w_addr = '0; w_data = '0;
    for (int a = 0; a < NA; a++) begin ram_m[a] = '0; lmem[a] = '0; end
    for (int b = 0; b < NB; b++) begin pv[b] = 1'b0; pa[b] = 0; pd[b] = '0; end
    @(posedge clk); #1;
    ram_clr = 1'b0;
    do_reset(2);

    // Direct write to bank 1, then read back
    drive(1'b0, 3'd0, 1'b1, 3'd3, 8'hA5);
    chk("wr3_bank_we", 32'(bank_we), 32'b10);
    chk("wr3_bank_en", 32'(bank_en), 32'b10);
    chk("wr3_row", 32'(bank_addr[BAW +: BAW]), 1);
    chk("wr3_wdata", 32'(bank_wdata[DW +: DW]), 32'hA5);
    step(acc);
    drive(1'b1, 3'd3, 1'b0, 3'd0, 8'h00); step(acc);
    idle();

    // Same-bank collision defers the write
    drive(1'b1, 3'd2, 1'b1, 3'd4, 8'h3C);
    chk("col_bank_en", 32'(bank_en), 32'b01);
    chk("col_bank_we", 32'(bank_we), 0);
    chk("col_row", 32'(bank_addr[0 +: BAW]), 1);
    step(acc);
    drive(1'b0, 3'd0, 1'b0, 3'd0, 8'h00);
    chk("drain_bank_we", 32'(bank_we), 32'b01);
    chk("drain_row", 32'(bank_addr[0 +: BAW]), 2);
    chk("drain_wdata", 32'(bank_wdata[0 +: DW]), 32'h3C);
    step(acc);
    idle();

    // Full slot plus read on same bank stalls the write
    drive(1'b1, 3'd2, 1'b1, 3'd4, 8'h11); step(acc);
    drive(1'b1, 3'd0, 1'b1, 3'd6, 8'h66);
    chk("stall_bank_we", 32'(bank_we), 0);
    step(acc);
    drive(1'b0, 3'd0, 1'b1, 3'd6, 8'h66);
    chk("refill_bank_we", 32'(bank_we), 32'b01);
    chk("refill_row", 32'(bank_addr[0 +: BAW]), 2);
    chk("refill_wdata", 32'(bank_wdata[0 +: DW]), 32'h11);
    step(acc);
    idle(); idle();

    // Read of a pending address: old RAM value, or forwarded data when enabled
    drive(1'b1, 3'd0, 1'b1, 3'd4, 8'h77); step(acc);
    drive(1'b1, 3'd4, 1'b0, 3'd0, 8'h00); step(acc);
    idle(); idle();

    // Reset with a pending slot: its write must never reach RAM
    drive(1'b1, 3'd0, 1'b1, 3'd2, 8'hEE); step(acc);
    do_reset(1);
    drive(1'b1, 3'd2, 1'b0, 3'd0, 8'h00); step(acc);
    idle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), AW'($urandom), 1'($urandom_range(0, 1)),
            AW'($urandom), DW'($urandom));
      step(acc);
    end
    idle(); idle();

    // Streaming writes with reads lagging by four
    for (int i = 0; i < 24; i++) begin
      tries = 0;
      do begin
        drive(1'(i >= 4 && tries == 0), AW'(i - 4), 1'b1, AW'(i), DW'(i * 7 + 1));
        step(acc);
        tries++;
      end while (!acc && tries < 4);
      chk("stream_accept", 32'(acc), 1);
    end

    for (int i = 0; i < 4; i++) idle();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
